mem_port_arbiter: RTL and testbench

- Arbitrates one single-ported memory among NREQ requesters: 0 = CPU data port (memdir/MRE/MWE), 1 = CPU fetch port (pcdir), 2 = external loader/debug.
- Round-robin, one outstanding transaction at a time.
- Fixed-latency memory timing; results returned through per-requester grant and read-valid pulses.
- Sits between the processor ports and the shared instruction/data RAM.

---
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency memory among NREQ requesters
// (0 = CPU data port, 1 = CPU fetch port, 2 = loader/debug). Requests are
// served one at a time in round-robin order. Each transaction walks
// IDLE -> ISSUE -> (WAIT x MEM_LAT -> RESP, reads only) -> IDLE.
//
// Parameters
//   bus      address/data width
//   NREQ     number of requesters (2..8)
//   MEM_LAT  cycles from mem_re to valid mem_rdata (1..15)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req, we            per-requester request and write flag
//   addr, wdata        per-requester address/write data, requester i at
//                      [i*bus +: bus]
//   gnt                one-hot grant pulse during the ISSUE cycle
//   rvalid, rdata      one-hot read-valid pulse (RESP) and read data;
//                      rdata holds its last value outside RESP
//   busy               high whenever the arbiter is not IDLE
//   mem_addr/mem_wdata memory address/write data (driven in ISSUE only)
//   mem_re/mem_we      memory read/write strobes (ISSUE only)
//   mem_rdata          memory read data
//
// Optional feature (macro ARB_PERF_CNT_EN)
//   Adds input cnt_clr and output grant_cnt[NREQ*16]: one saturating 16-bit
//   grant counter per requester, requester i at [i*16 +: 16]. cnt_clr
//   zeroes all counters and takes priority over a same-cycle increment.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int bus     = 32,
    parameter int NREQ    = 3,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     we,
    input  logic [NREQ*bus-1:0] addr,
    input  logic [NREQ*bus-1:0] wdata,
`ifdef ARB_PERF_CNT_EN
    input  logic                cnt_clr,
    output logic [NREQ*16-1:0]  grant_cnt,
`endif
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvalid,
    output logic [bus-1:0]      rdata,
    output logic                busy,
    output logic [bus-1:0]      mem_addr,
    output logic [bus-1:0]      mem_wdata,
    output logic                mem_re,
    output logic                mem_we,
    input  logic [bus-1:0]      mem_rdata
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [PTR_W-1:0]   ptr;        // last granted requester
    logic [PTR_W-1:0]   owner;      // requester owning the current transaction
    logic [PTR_W-1:0]   win_next;
    logic               win_found;

    logic [bus-1:0]     addr_lat;
    logic [bus-1:0]     wdata_lat;
    logic               we_lat;
    logic [CNT_W-1:0]   lat_cnt;
    logic [bus-1:0]     rdata_q;

    // (base + k) modulo NREQ, for k in 1..NREQ
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                  input int               k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return PTR_W'(sum);
    endfunction

    // Round-robin search starting just after the last winner
    always_comb begin
        win_found = 1'b0;
        win_next  = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req[rr_index(ptr, k)]) begin
                win_found = 1'b1;
                win_next  = rr_index(ptr, k);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found) state_next = ISSUE;
            ISSUE:   state_next = we_lat ? IDLE : WAIT;
            WAIT:    if (lat_cnt == CNT_W'(MEM_LAT)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; everything is zero outside its own state
    always_comb begin
        gnt       = '0;
        rvalid    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            ISSUE: begin
                gnt[owner] = 1'b1;
                mem_addr   = addr_lat;
                mem_wdata  = wdata_lat;
                mem_re     = ~we_lat;
                mem_we     = we_lat;
            end
            RESP: begin
                rvalid[owner] = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (state != IDLE);
    assign rdata = rdata_q;

    // State register and transaction bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= PTR_W'(NREQ - 1);
            owner     <= '0;
            addr_lat  <= '0;
            wdata_lat <= '0;
            we_lat    <= 1'b0;
            lat_cnt   <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                // Requests are only looked at here; the winner is latched so
                // the requester may drop its signals from the grant onward.
                IDLE: begin
                    if (win_found) begin
                        owner     <= win_next;
                        addr_lat  <= addr[win_next*bus +: bus];
                        wdata_lat <= wdata[win_next*bus +: bus];
                        we_lat    <= we[win_next];
                    end
                end
                ISSUE: begin
                    ptr     <= owner;
                    lat_cnt <= CNT_W'(1);
                end
                // lat_cnt == k during the k-th cycle after the read strobe
                WAIT: begin
                    lat_cnt <= lat_cnt + CNT_W'(1);
                    if (lat_cnt == CNT_W'(MEM_LAT)) begin
                        rdata_q <= mem_rdata;
                    end
                end
                RESP: begin
                    lat_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] gcnt [NREQ];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                gcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cnt_clr) begin
                    gcnt[i] <= '0;
                end else if (gnt[i]) begin
                    gcnt[i] <= sat_inc(gcnt[i]);
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
        assign grant_cnt[g*16 +: 16] = gcnt[g];
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances share all requester
// inputs: dut2 (MEM_LAT=2) and dut3 (MEM_LAT=3). Each has its own small
// memory model that only presents valid data exactly MEM_LAT cycles after
// mem_re, so a capture on the wrong cycle returns a poison value.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [95:0] addr;
    logic [95:0] wdata;
    logic [31:0] mem_val;

    logic [2:0]  gnt2, rvalid2, gnt3, rvalid3;
    logic [31:0] rdata2, rdata3, mem_addr2, mem_addr3, mem_wdata2, mem_wdata3;
    logic [31:0] mem_rdata2, mem_rdata3;
    logic        busy2, busy3, mem_re2, mem_re3, mem_we2, mem_we3;
`ifdef ARB_PERF_CNT_EN
    logic        cnt_clr;
    logic [47:0] grant_cnt2, grant_cnt3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.bus(32), .NREQ(3), .MEM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef ARB_PERF_CNT_EN
        .cnt_clr(cnt_clr), .grant_cnt(grant_cnt2),
`endif
        .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2), .busy(busy2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_re(mem_re2),
        .mem_we(mem_we2), .mem_rdata(mem_rdata2)
    );

    mem_port_arbiter #(.bus(32), .NREQ(3), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef ARB_PERF_CNT_EN
        .cnt_clr(cnt_clr), .grant_cnt(grant_cnt3),
`endif
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_re(mem_re3),
        .mem_we(mem_we3), .mem_rdata(mem_rdata3)
    );

    // Fixed-latency memory models: re_shN[k] is mem_re delayed k+1 cycles
    logic [3:0] re_sh2 = '0;
    logic [3:0] re_sh3 = '0;
    always @(posedge clk) begin
        re_sh2 <= {re_sh2[2:0], mem_re2};
        re_sh3 <= {re_sh3[2:0], mem_re3};
    end
    assign mem_rdata2 = re_sh2[1] ? mem_val : 32'h0BAD0BAD;
    assign mem_rdata3 = re_sh3[2] ? mem_val : 32'h0BAD0BAD;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int idx_of(input logic [2:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        mem_val = '0;
`ifdef ARB_PERF_CNT_EN
        cnt_clr = 1'b0;
`endif
        idle(2);
        checks++;
        if ({gnt2, rvalid2, busy2, mem_re2, mem_we2} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {gnt2, rvalid2, busy2, mem_re2, mem_we2});
        end
        checks++;
        if ({mem_addr2, mem_wdata2, rdata2} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr2, mem_wdata2, rdata2});
        end
        rst_n = 1'b1;
        idle(2);
        checks++;
        if ({gnt2, busy2, mem_re2, mem_we2} !== 6'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 0", {gnt2, busy2, mem_re2, mem_we2});
        end
    endtask

    task automatic test_read;
        int busy_cnt;
        int rv_cycle;
        logic [2:0]  rv_val;
        logic [31:0] rd_val;
        busy_cnt = 0;
        rv_cycle = -1;
        rv_val   = '0;
        rd_val   = '0;
        mem_val  = 32'hDEADBEEF;
        req      = 3'b010;
        we       = 3'b000;
        addr[32 +: 32] = 32'h40;
        @(negedge clk);                 // cycle T+1
        checks++;
        if (gnt2 !== 3'b010) begin
            errors++;
            $display("FAIL read_gnt: got %b expected 010", gnt2);
        end
        checks++;
        if ({mem_re2, mem_we2, mem_addr2} !== {2'b10, 32'h40}) begin
            errors++;
            $display("FAIL read_strobe: got re=%b we=%b addr=%h expected re=1 we=0 addr=00000040",
                     mem_re2, mem_we2, mem_addr2);
        end
        if (busy2) busy_cnt++;
        req = '0;
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);             // cycle T+c
            if (busy2) busy_cnt++;
            if (rvalid2 != 3'b000 && rv_cycle < 0) begin
                rv_cycle = c;
                rv_val   = rvalid2;
                rd_val   = rdata2;
            end
        end
        checks++;
        if (rv_cycle != 4) begin
            errors++;
            $display("FAIL read_latency: got rvalid at T+%0d expected T+4", rv_cycle);
        end
        checks++;
        if ({rv_val, rd_val} !== {3'b010, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL read_data: got rvalid=%b rdata=%h expected 010 deadbeef", rv_val, rd_val);
        end
        checks++;
        if (busy_cnt != 4) begin
            errors++;
            $display("FAIL read_busy: got %0d cycles expected 4", busy_cnt);
        end
        mem_val = 32'h0;
        idle(2);
        checks++;
        if (rdata2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdata_hold: got %h expected deadbeef", rdata2);
        end
        idle(4);
    endtask

    task automatic test_write;
        int busy_cnt;
        int rv_seen;
        busy_cnt = 0;
        rv_seen  = 0;
        req = 3'b001;
        we  = 3'b001;
        addr[0 +: 32]  = 32'h100;
        wdata[0 +: 32] = 32'h12345678;
        @(negedge clk);
        checks++;
        if (gnt2 !== 3'b001) begin
            errors++;
            $display("FAIL write_gnt: got %b expected 001", gnt2);
        end
        checks++;
        if ({mem_we2, mem_re2, mem_addr2, mem_wdata2} !== {2'b10, 32'h100, 32'h12345678}) begin
            errors++;
            $display("FAIL write_strobe: got we=%b re=%b addr=%h wdata=%h expected 1 0 00000100 12345678",
                     mem_we2, mem_re2, mem_addr2, mem_wdata2);
        end
        if (busy2) busy_cnt++;
        req = '0;
        we  = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy2) busy_cnt++;
            if (rvalid2 != 3'b000) rv_seen++;
            if (mem_we2) busy_cnt += 10;    // strobe longer than one cycle
        end
        checks++;
        if (busy_cnt != 1) begin
            errors++;
            $display("FAIL write_busy: got %0d expected 1", busy_cnt);
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL write_no_rvalid: got %0d rvalid cycles expected 0", rv_seen);
        end
        idle(2);
    endtask

    task automatic test_round_robin;
        int order [6];
        int n;
        int bad_onehot;
        int overlap;
        n = 0;
        bad_onehot = 0;
        overlap = 0;
        mem_val = 32'hCAFEF00D;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 3'b111;
        we  = 3'b000;
        for (int c = 0; c < 80 && n < 6; c++) begin
            @(negedge clk);
            if (!$onehot0(gnt2) || !$onehot0(rvalid2)) bad_onehot++;
            if (mem_re2 && mem_we2) overlap++;
            if (gnt2 != 3'b000) begin
                order[n] = idx_of(gnt2);
                n++;
                if (n == 6) req = '0;
            end
        end
        req = '0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL rr_count: got %0d grants expected 6", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != i % 3) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % 3);
            end
        end
        checks++;
        if (bad_onehot != 0 || overlap != 0) begin
            errors++;
            $display("FAIL rr_exclusive: got onehot_viol=%0d re_we_overlap=%0d expected 0 0",
                     bad_onehot, overlap);
        end
        idle(8);
    endtask

    task automatic test_rr_priority;
        int got [2];
        int n;
        n = 0;
        req = 3'b010;
        we  = 3'b000;
        for (int c = 0; c < 20 && n == 0; c++) begin
            @(negedge clk);
            if (gnt2 != 3'b000) n = 1;
        end
        req = '0;
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL prio_setup: got no grant expected gnt[1]");
        end
        idle(8);
        n = 0;
        req = 3'b110;
        for (int c = 0; c < 40 && n < 2; c++) begin
            @(negedge clk);
            if (gnt2 != 3'b000) begin
                got[n] = idx_of(gnt2);
                n++;
                if (n == 2) req = '0;
            end
        end
        req = '0;
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL prio_count: got %0d grants expected 2", n);
        end else begin
            checks++;
            if (got[0] != 2 || got[1] != 1) begin
                errors++;
                $display("FAIL prio_order: got %0d,%0d expected 2,1", got[0], got[1]);
            end
        end
        idle(8);
    endtask

    task automatic test_reset_mid;
        int rv_seen;
        rv_seen = 0;
        req = 3'b010;
        we  = 3'b000;
        addr[32 +: 32] = 32'h80;
        @(negedge clk);                 // ISSUE
        checks++;
        if (gnt3 !== 3'b010) begin
            errors++;
            $display("FAIL mid_setup_gnt: got %b expected 010", gnt3);
        end
        req = '0;
        @(negedge clk);                 // first WAIT cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt3, rvalid3, busy3, mem_re3, mem_we3} !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %b expected 0", {gnt3, rvalid3, busy3, mem_re3, mem_we3});
        end
        checks++;
        if ({mem_addr3, mem_wdata3, rdata3} !== 96'd0) begin
            errors++;
            $display("FAIL mid_reset_data: got %h expected 0", {mem_addr3, mem_wdata3, rdata3});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rvalid3 != 3'b000) rv_seen++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rvalid3 != 3'b000) rv_seen++;
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL mid_no_rvalid: got %0d rvalid cycles expected 0", rv_seen);
        end
        req = 3'b011;
        @(negedge clk);
        checks++;
        if (gnt3 !== 3'b001) begin
            errors++;
            $display("FAIL mid_first_gnt: got %b expected 001", gnt3);
        end
        req = '0;
        idle(8);
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf_cnt;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++;
        if (grant_cnt2 !== 48'd0) begin
            errors++;
            $display("FAIL cnt_clear_init: got %h expected 0", grant_cnt2);
        end
        req = 3'b001;
        we  = 3'b001;
        repeat (140000) @(negedge clk);
        req = '0;
        we  = '0;
        idle(4);
        checks++;
        if (grant_cnt2 !== {32'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL cnt_saturate: got %h expected 00000000ffff", grant_cnt2);
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++;
        if (grant_cnt2[15:0] !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr: got %h expected 0000", grant_cnt2[15:0]);
        end
        req = 3'b010;
        we  = 3'b010;
        @(negedge clk);
        req = '0;
        we  = '0;
        idle(3);
        checks++;
        if (grant_cnt2 !== {16'd0, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL cnt_per_req: got %h expected 000000010000", grant_cnt2);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_read;
        test_write;
        test_round_robin;
        test_rr_priority;
        test_reset_mid;
`ifdef ARB_PERF_CNT_EN
        test_perf_cnt;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
